next_pc_unit: RTL and testbench

//  Registered next-PC generator for the KGP-RISC fetch stage.
//  - Holds the architectural PC and computes the next PC from the branch class, opcode and ALU flags.
//  - Adds a stall hold, a post-redirect flush window and full opcode decode; undecoded cases fall through.
//  - Sits between the decoder/ALU flag register and instruction memory.

---
 rtl/npc_pkg.sv | 25 ++
 rtl/next_pc_unit_if.sv | 32 +++
 rtl/npc_ras.sv | 46 ++++
 rtl/next_pc_unit.sv | 147 ++++++++++++++
 tb/tb_next_pc_unit.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/npc_pkg.sv
// Shared encodings for the KGP-RISC next-PC unit: branch classes, branch opcodes, FSM states.
package npc_pkg;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_IMM = 2'b01;
  localparam logic [1:0] SEL_LBL = 2'b10;
  localparam logic [1:0] SEL_REG = 2'b11;

  localparam logic [5:0] OP_BSG = 6'b010011;
  localparam logic [5:0] OP_BZ  = 6'b010100;
  localparam logic [5:0] OP_BNZ = 6'b010101;
  localparam logic [5:0] OP_B   = 6'b100000;
  localparam logic [5:0] OP_BL  = 6'b100001;
  localparam logic [5:0] OP_BCY = 6'b100010;
  localparam logic [5:0] OP_BNC = 6'b100011;
  localparam logic [5:0] OP_RET = 6'b110001;

  localparam int unsigned CNT_W = 3;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } npc_state_e;

endpackage

// File: rtl/next_pc_unit_if.sv
// Fetch-side bundle between decoder/ALU flags and the next-PC unit.
interface next_pc_unit_if #(
  parameter int unsigned AW = 32
);
  logic          stall;
  logic          instr_valid;
  logic [1:0]    instr_select;
  logic [5:0]    opcode;
  logic          carry_flag;
  logic          zero_flag;
  logic          sign_flag;
  logic [AW-1:0] rs_data;
  logic [AW-1:0] imm2;
  logic [AW-1:0] label;
  logic [AW-1:0] pc;
  logic [AW-1:0] npc;
  logic          taken;
  logic          flush;
  logic          ras_overflow;

  modport master (
    output stall, instr_valid, instr_select, opcode, carry_flag, zero_flag, sign_flag,
    output rs_data, imm2, label,
    input  pc, npc, taken, flush, ras_overflow
  );

  modport slave (
    input  stall, instr_valid, instr_select, opcode, carry_flag, zero_flag, sign_flag,
    input  rs_data, imm2, label,
    output pc, npc, taken, flush, ras_overflow
  );
endinterface

// File: rtl/npc_ras.sv
// Circular return-address stack; a push into a full stack overwrites the oldest entry.
module npc_ras #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [AW-1:0] i_data,
  output logic [AW-1:0] o_top,
  output logic          o_empty,
  output logic          o_full
);
  localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned SLOTS = 1 << IW;

  logic [AW-1:0] r_mem [SLOTS];
  logic [IW-1:0] r_sp;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] w_wr_idx;

  assign w_wr_idx = r_sp + IW'(1);
  assign o_top    = r_mem[r_sp];
  assign o_empty  = (r_cnt == '0);
  assign o_full   = (r_cnt == CW'(DEPTH));

  // Pointer wraps naturally; when full the next slot is the oldest entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp  <= '0;
      r_cnt <= '0;
    end else if (i_push) begin
      r_sp <= w_wr_idx;
      if (!o_full) r_cnt <= r_cnt + CW'(1);
    end else if (i_pop && !o_empty) begin
      r_sp  <= r_sp - IW'(1);
      r_cnt <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[w_wr_idx] <= i_data;
  end
endmodule

// File: rtl/next_pc_unit.sv
// Registered next-PC generator with stall hold and post-redirect flush window.
// Define NPC_RAS_EN to add a return-address stack for bl/ret.
module next_pc_unit
  import npc_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned INC          = 1,
  parameter int unsigned RESET_PC     = 0,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input logic           clk,
  input logic           rst_n,
  next_pc_unit_if.slave bus
);
  logic [AW-1:0]    r_pc;
  logic [AW-1:0]    w_seq;
  logic [AW-1:0]    w_target;
  logic [AW-1:0]    w_npc;
  logic             w_hit;
  logic             w_active;
  logic             w_taken;
  npc_state_e       r_state;
  npc_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_flush;

`ifdef NPC_RAS_EN
  logic [AW-1:0] w_ras_top;
  logic          w_ras_empty;
  logic          w_ras_full;
  logic          w_ras_push;
  logic          w_ras_pop;
  logic          r_ras_ovf;
`endif

  assign w_seq    = r_pc + AW'(INC);
  assign w_active = bus.instr_valid && (r_state == ST_RUN);
  assign w_taken  = w_active && w_hit;
  assign w_npc    = w_taken ? w_target : w_seq;

  // Branch decode: unrecognised opcodes fall through to the sequential PC.
  always_comb begin
    w_hit    = 1'b0;
    w_target = w_seq;
    case (bus.instr_select)
      SEL_IMM: begin
        w_target = bus.imm2;
        case (bus.opcode)
          OP_BSG:  w_hit = bus.sign_flag;
          OP_BZ:   w_hit = bus.zero_flag;
          OP_BNZ:  w_hit = !bus.zero_flag;
          default: w_hit = 1'b0;
        endcase
      end
      SEL_LBL: begin
        w_target = bus.label;
        case (bus.opcode)
          OP_B, OP_BL: w_hit = 1'b1;
          OP_BCY:      w_hit = bus.carry_flag;
          OP_BNC:      w_hit = !bus.carry_flag;
          default:     w_hit = 1'b0;
        endcase
      end
      SEL_REG: begin
        w_hit    = 1'b1;
        w_target = bus.rs_data;
`ifdef NPC_RAS_EN
        if (bus.opcode == OP_RET && !w_ras_empty) w_target = w_ras_top;
`endif
      end
      default: w_hit = 1'b0;
    endcase
  end

  // Next state: stall freezes pc, state and counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!bus.stall) begin
      case (r_state)
        ST_RUN: begin
          if (w_taken) begin
            w_state_nxt = ST_FLUSH;
            w_cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
          end
        end
        ST_FLUSH: begin
          if (r_cnt == '0) w_state_nxt = ST_RUN;
          else             w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= AW'(RESET_PC);
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_flush <= 1'b0;
    end else begin
      if (!bus.stall) r_pc <= w_npc;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_flush <= (w_state_nxt == ST_FLUSH);
    end
  end

  assign bus.pc    = r_pc;
  assign bus.npc   = w_npc;
  assign bus.taken = w_taken;
  assign bus.flush = r_flush;

`ifdef NPC_RAS_EN
  assign w_ras_push = w_taken && !bus.stall && (bus.instr_select == SEL_LBL) && (bus.opcode == OP_BL);
  assign w_ras_pop  = w_taken && !bus.stall && (bus.instr_select == SEL_REG) && (bus.opcode == OP_RET);

  npc_ras #(
    .AW    (AW),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_ras_push),
    .i_pop   (w_ras_pop),
    .i_data  (w_seq),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty),
    .o_full  (w_ras_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_ras_ovf <= 1'b0;
    else if (w_ras_push && w_ras_full) r_ras_ovf <= 1'b1;
  end

  assign bus.ras_overflow = r_ras_ovf;
`else
  // Without the stack, ret is an ordinary register jump and RAS_DEPTH has no effect.
  logic w_unused_cfg;
  assign w_unused_cfg     = (RAS_DEPTH == 0) || (bus.opcode == OP_RET);
  assign bus.ras_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_next_pc_unit.sv
// Directed testbench for next_pc_unit (AW=8, FLUSH_CYCLES=3); RAS checks follow NPC_RAS_EN.
module tb_next_pc_unit;
  import npc_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned FC = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  next_pc_unit_if #(.AW(AW)) bus ();

  next_pc_unit #(
    .AW           (AW),
    .INC          (1),
    .RESET_PC     (0),
    .FLUSH_CYCLES (FC),
    .RAS_DEPTH    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [5:0] op);
    bus.stall        = 1'b0;
    bus.instr_valid  = v;
    bus.instr_select = sel;
    bus.opcode       = op;
  endtask

  task automatic wait_run();
    int k;
    k = 0;
    while (bus.flush !== 1'b0 && k < 16) begin
      tick();
      k++;
    end
    n_tests++;
    if (bus.flush !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_run: flush=%b want 0 within 16 cycles", bus.flush);
    end
  endtask

  // Jump to t-FC so the flush bubbles land the pc exactly on t in RUN.
  task automatic goto(input logic [AW-1:0] t);
    wait_run();
    bus.rs_data = t - AW'(FC);
    drive(1'b1, SEL_REG, 6'b000000);
    tick();
    drive(1'b1, SEL_SEQ, 6'b000000);
    repeat (FC) tick();
  endtask

  task automatic test_reset();
    bus.carry_flag = 1'b0;
    bus.zero_flag  = 1'b0;
    bus.sign_flag  = 1'b0;
    bus.rs_data    = '0;
    bus.imm2       = '0;
    bus.label      = '0;
    drive(1'b1, SEL_SEQ, 6'b000000);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h want 00", bus.pc); end
    n_tests++;
    if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", bus.flush); end
    n_tests++;
    if (bus.ras_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.ras_overflow); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_seq();
    n_tests++;
    if (bus.npc !== 8'h01 || bus.taken !== 1'b0) begin
      n_fail++; $display("FAIL seq_npc: got npc=%h taken=%b want 01/0", bus.npc, bus.taken);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_tests++;
      if (bus.pc !== AW'(i) || bus.flush !== 1'b0) begin
        n_fail++; $display("FAIL seq_pc[%0d]: got pc=%h flush=%b want %h/0", i, bus.pc, bus.flush, AW'(i));
      end
    end
  endtask

  // Combinational decode under stall at pc=4: targets imm2=40 label=50 rs=60, seq=05.
  task automatic test_decode();
    logic [12:0]   vec [18];
    logic [12:0]   e;
    logic [AW-1:0] exp_npc;
    vec = '{13'b1_01_010011_001_1, 13'b1_01_010011_000_0, 13'b1_01_010100_010_1,
            13'b1_01_010100_000_0, 13'b1_01_010101_000_1, 13'b1_01_010101_010_0,
            13'b1_01_111111_111_0, 13'b1_10_100000_000_1, 13'b1_10_100001_000_1,
            13'b1_10_100010_100_1, 13'b1_10_100010_000_0, 13'b1_10_100011_000_1,
            13'b1_10_100011_100_0, 13'b1_10_000000_111_0, 13'b1_11_000000_000_1,
            13'b1_00_010100_111_0, 13'b0_11_000000_000_0, 13'b1_01_100000_111_0};
    bus.imm2    = 8'h40;
    bus.label   = 8'h50;
    bus.rs_data = 8'h60;
    for (int i = 0; i < 18; i++) begin
      e = vec[i];
      drive(e[12], e[11:10], e[9:4]);
      bus.stall      = 1'b1;
      bus.carry_flag = e[3];
      bus.zero_flag  = e[2];
      bus.sign_flag  = e[1];
      #1;
      if (!e[0])                exp_npc = 8'h05;
      else if (e[11:10] == 2'b01) exp_npc = 8'h40;
      else if (e[11:10] == 2'b10) exp_npc = 8'h50;
      else                      exp_npc = 8'h60;
      n_tests++;
      if (bus.taken !== e[0] || bus.npc !== exp_npc) begin
        n_fail++; $display("FAIL decode[%0d]: got taken=%b npc=%h want %b/%h", i, bus.taken, bus.npc, e[0], exp_npc);
      end
    end
    n_tests++;
    if (bus.pc !== 8'h04 || bus.flush !== 1'b0) begin
      n_fail++; $display("FAIL decode_hold: got pc=%h flush=%b want 04/0", bus.pc, bus.flush);
    end
    bus.carry_flag = 1'b0;
    bus.zero_flag  = 1'b0;
    bus.sign_flag  = 1'b0;
  endtask

  task automatic test_imm_branch();
    drive(1'b1, SEL_SEQ, 6'b000000);
    tick();
    n_tests++;
    if (bus.pc !== 8'h05) begin n_fail++; $display("FAIL imm_pre: got %h want 05", bus.pc); end
    bus.imm2      = 8'd40;
    bus.zero_flag = 1'b1;
    drive(1'b1, SEL_IMM, OP_BZ);
    #1;
    n_tests++;
    if (bus.taken !== 1'b1 || bus.npc !== 8'd40) begin
      n_fail++; $display("FAIL imm_taken: got taken=%b npc=%h want 1/28", bus.taken, bus.npc);
    end
    tick();
    n_tests++;
    if (bus.pc !== 8'd40 || bus.flush !== 1'b1) begin
      n_fail++; $display("FAIL imm_target: got pc=%h flush=%b want 28/1", bus.pc, bus.flush);
    end
    n_tests++;
    if (bus.taken !== 1'b0 || bus.npc !== 8'd41) begin
      n_fail++; $display("FAIL flush_notaken: got taken=%b npc=%h want 0/29", bus.taken, bus.npc);
    end
    for (int i = 1; i <= int'(FC); i++) begin
      tick();
      n_tests++;
      if (bus.pc !== AW'(40 + i) || bus.flush !== (i < int'(FC))) begin
        n_fail++; $display("FAIL flush_window[%0d]: got pc=%h flush=%b want %h/%b", i, bus.pc, bus.flush, AW'(40 + i), (i < int'(FC)));
      end
    end
    goto(8'd5);
    bus.zero_flag = 1'b0;
    drive(1'b1, SEL_IMM, OP_BZ);
    #1;
    n_tests++;
    if (bus.taken !== 1'b0) begin n_fail++; $display("FAIL imm_nt: got taken=%b want 0", bus.taken); end
    tick();
    n_tests++;
    if (bus.pc !== 8'd6 || bus.flush !== 1'b0) begin
      n_fail++; $display("FAIL imm_nt_pc: got pc=%h flush=%b want 06/0", bus.pc, bus.flush);
    end
  endtask

  task automatic test_stall();
    bus.carry_flag = 1'b1;
    bus.label      = 8'h80;
    drive(1'b1, SEL_LBL, OP_BCY);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (bus.pc !== 8'd6 || bus.flush !== 1'b0 || bus.taken !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got pc=%h flush=%b taken=%b want 06/0/1", i, bus.pc, bus.flush, bus.taken);
      end
    end
    bus.stall = 1'b0;
    tick();
    n_tests++;
    if (bus.pc !== 8'h80 || bus.flush !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: got pc=%h flush=%b want 80/1", bus.pc, bus.flush);
    end
    bus.stall = 1'b1;
    tick();
    n_tests++;
    if (bus.pc !== 8'h80 || bus.flush !== 1'b1) begin
      n_fail++; $display("FAIL stall_in_flush: got pc=%h flush=%b want 80/1", bus.pc, bus.flush);
    end
    bus.stall = 1'b0;
    for (int i = 1; i <= int'(FC); i++) begin
      tick();
      n_tests++;
      if (bus.pc !== AW'(8'h80 + i) || bus.flush !== (i < int'(FC))) begin
        n_fail++; $display("FAIL stall_flush[%0d]: got pc=%h flush=%b want %h/%b", i, bus.pc, bus.flush, AW'(8'h80 + i), (i < int'(FC)));
      end
    end
    drive(1'b1, SEL_LBL, 6'b111111);
    tick();
    n_tests++;
    if (bus.pc !== 8'h84 || bus.flush !== 1'b0) begin
      n_fail++; $display("FAIL lbl_unknown: got pc=%h flush=%b want 84/0", bus.pc, bus.flush);
    end
    bus.carry_flag = 1'b0;
  endtask

  task automatic test_wrap();
    goto(8'hFF);
    n_tests++;
    if (bus.pc !== 8'hFF) begin n_fail++; $display("FAIL wrap_pre: got %h want ff", bus.pc); end
    drive(1'b1, SEL_SEQ, 6'b000000);
    tick();
    n_tests++;
    if (bus.pc !== 8'h00) begin n_fail++; $display("FAIL wrap: got %h want 00", bus.pc); end
    bus.rs_data = 8'h33;
    drive(1'b1, SEL_REG, 6'b000000);
    tick();
    n_tests++;
    if (bus.pc !== 8'h33 || bus.flush !== 1'b1) begin
      n_fail++; $display("FAIL reg_jump: got pc=%h flush=%b want 33/1", bus.pc, bus.flush);
    end
  endtask

  task automatic test_reset_mid_flush();
    drive(1'b1, SEL_SEQ, 6'b000000);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.pc !== 8'h00 || bus.flush !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got pc=%h flush=%b want 00/0", bus.pc, bus.flush);
    end
    #1 rst_n = 1'b1;
    tick();
    n_tests++;
    if (bus.pc !== 8'h01 || bus.flush !== 1'b0) begin
      n_fail++; $display("FAIL post_reset: got pc=%h flush=%b want 01/0", bus.pc, bus.flush);
    end
  endtask

`ifdef NPC_RAS_EN
  task automatic test_ras();
    logic [AW-1:0] exp_ret [5];
    exp_ret = '{8'd51, 8'd41, 8'd31, 8'd21, 8'd99};
    bus.label = 8'h90;
    for (int i = 1; i <= 5; i++) begin
      goto(AW'(10 * i));
      drive(1'b1, SEL_LBL, OP_BL);
      tick();
      n_tests++;
      if (bus.pc !== 8'h90 || bus.ras_overflow !== (i == 5)) begin
        n_fail++; $display("FAIL bl[%0d]: got pc=%h ovf=%b want 90/%b", i, bus.pc, bus.ras_overflow, (i == 5));
      end
    end
    bus.rs_data = 8'd99;
    for (int i = 0; i < 5; i++) begin
      wait_run();
      drive(1'b1, SEL_REG, OP_RET);
      tick();
      n_tests++;
      if (bus.pc !== exp_ret[i]) begin
        n_fail++; $display("FAIL ret[%0d]: got pc=%h want %h", i, bus.pc, exp_ret[i]);
      end
    end
  endtask
`else
  task automatic test_ras();
    bus.label = 8'h90;
    goto(8'd10);
    drive(1'b1, SEL_LBL, OP_BL);
    tick();
    n_tests++;
    if (bus.pc !== 8'h90) begin n_fail++; $display("FAIL bl: got pc=%h want 90", bus.pc); end
    wait_run();
    bus.rs_data = 8'h55;
    drive(1'b1, SEL_REG, OP_RET);
    tick();
    n_tests++;
    if (bus.pc !== 8'h55 || bus.ras_overflow !== 1'b0) begin
      n_fail++; $display("FAIL ret_plain: got pc=%h ovf=%b want 55/0", bus.pc, bus.ras_overflow);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_seq();
    test_decode();
    test_imm_branch();
    test_stall();
    test_wrap();
    test_reset_mid_flush();
    test_ras();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
